// File: rtl/risk_cmd_queue.sv
// risk_cmd_queue: small command FIFO in front of the risk matrix unit.
// Accepts commands over valid/ready, replays each onto the risk_* inputs and
// holds it for HOLD cycles (1 cycle for NOP), back-to-back with no bubble.
module risk_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_func,
    input  logic [4:0]               cmd_reg,
    input  logic [14:0]              cmd_addr,
    input  logic [13:0]              cmd_stride_x,
    input  logic [13:0]              cmd_stride_y,
    output logic [2:0]               risk_func,
    output logic [4:0]               risk_reg,
    output logic [14:0]              risk_addr,
    output logic [13:0]              risk_stride_x,
    output logic [13:0]              risk_stride_y,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef struct packed {
        logic [2:0]  func;
        logic [4:0]  idx;
        logic [14:0] addr;
        logic [13:0] sx;
        logic [13:0] sy;
    } cmd_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    cmd_t          r_out;
    cmd_t          w_out_nxt;

    cmd_t          w_in;
    cmd_t          w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_load;

    assign w_in      = {cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y};
    assign w_head    = r_mem[r_rptr];
    assign cmd_ready = resetn && (r_level != FULL);
    assign w_push    = cmd_valid && cmd_ready;

    assign risk_func     = r_out.func;
    assign risk_reg      = r_out.idx;
    assign risk_addr     = r_out.addr;
    assign risk_stride_x = r_out.sx;
    assign risk_stride_y = r_out.sy;
    assign busy          = (r_state == ST_ISSUE) || (r_level != '0);
    assign level         = r_level;

    // Next-state, hold counter and issued-command selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_level != '0) begin
                    w_load = 1'b1;
                end else begin
                    w_out_nxt.func = 3'b000;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Loading pops the head; a NOP occupies a single cycle.
        if (w_load) begin
            w_pop       = 1'b1;
            w_out_nxt   = w_head;
            w_state_nxt = ST_ISSUE;
            w_cnt_nxt   = (w_head.func == 3'b000) ? '0 : CNT_LOAD;
        end
    end

    // FSM state, hold counter and risk output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage; write is blocked during reset since cmd_ready is low.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

endmodule
